hvac_actuator_ctrl: RTL and testbench
=====================================

Name: hvac_actuator_ctrl

Overview:
- Downstream stage of the air-conditioning controller.
- Consumes its `heating`/`cooling` request outputs and drives the physical heater, compressor (cooler) and fan enables.
- Enforces compressor/heater protection: minimum run time, a minimum off (lockout) time between any two runs, fan run-on after a run, and mutual exclusion of heater and cooler.
- Flags conflicting requests.

Parameters:
- MIN_ON, 4: minimum number of cycles heater_on/cooler_on stays high once asserted (≥1).
- MIN_OFF, 3: number of cycles spent in LOCKOUT after every run (≥1).
- FAN_RUNON, 2: number of LOCKOUT cycles during which fan_on stays high (0..MIN_OFF).
- CNT_W, 8: timer width; MIN_ON and MIN_OFF must be ≤ 2^CNT_W−1.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- heating  input  1  heat request from the air-conditioning controller.
- cooling  input  1  cool request from the air-conditioning controller.
- heater_on  output  1  heater enable, registered.
- cooler_on  output  1  compressor enable, registered.
- fan_on  output  1  fan enable, registered.
- req_conflict  output  1  registered; high the cycle after heating&cooling is sampled high.
- state  output  2  current FSM state: OFF=0, HEAT=1, COOL=2, LOCKOUT=3.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (rst_n low, any time, including mid-run):
  - state=OFF; timer=0.
  - heater_on, cooler_on, fan_on and req_conflict all 0, immediately and without waiting for a clock edge.
  - Operation resumes at the first rising edge after rst_n is released.
- All outputs are registered and decoded from the next-state/timer at the clock edge:
  - heater_on=1 only in HEAT.
  - cooler_on=1 only in COOL.
  - heater_on and cooler_on are never high together.
- fan_on=1:
  - in HEAT and COOL;
  - in LOCKOUT while timer ≤ FAN_RUNON (i.e. the first FAN_RUNON LOCKOUT cycles);
  - otherwise 0.
- req_conflict <= heating & cooling every edge, in all states.
- Timer:
  - Loaded with 1 on the edge entering HEAT, COOL or LOCKOUT.
  - Increments each cycle in those states, saturating at 2^CNT_W−1.
  - Held at 0 in OFF.
- Transitions, evaluated at each rising edge:
  - OFF: heating&!cooling → HEAT; cooling&!heating → COOL; both or neither → stay OFF.
  - HEAT: !heating && timer≥MIN_ON → LOCKOUT; else stay. The cooling input is ignored here except for req_conflict.
  - COOL: !cooling && timer≥MIN_ON → LOCKOUT; else stay. The heating input is ignored here except for req_conflict.
  - LOCKOUT: timer≥MIN_OFF → OFF; else stay. All requests are ignored.
- Latency:
  - A request sampled high in OFF at edge N gives enable high from edge N (visible in cycle N..N+1).
  - An enable is high for max(MIN_ON, number of edges at which the request was sampled high) cycles.
  - LOCKOUT lasts exactly MIN_OFF cycles.
  - OFF lasts at least 1 cycle.
  - Minimum gap between an enable falling and any enable rising is MIN_OFF+1 cycles.
- Mode change (heat→cool or cool→heat) always passes through LOCKOUT then OFF; there is no direct HEAT↔COOL edge.
- A request pulse shorter than MIN_ON still produces a full MIN_ON-cycle run.
- Requests that appear during LOCKOUT are not latched; they are acted on only if still present when OFF is reached.

Test Plan (MIN_ON=4, MIN_OFF=3, FAN_RUNON=2):
1. Single-cycle pulse: heating high for 1 cycle from OFF, sampled at edge N → heater_on=1 and fan_on=1 for edges N..N+3. At N+4, state=LOCKOUT and heater_on=0, with fan_on=1 for 2 cycles then 0. state=OFF at edge N+7.
2. Long request: heating sampled high at 10 consecutive edges, then low → heater_on high exactly 10 cycles, followed by a 3-cycle LOCKOUT, then OFF.
3. Changeover: heating falls and cooling rises at the same edge after a 6-cycle heat run → heater_on falls at edge E; cooler_on rises at E+4, never overlapping. state sequence is 1,3,3,3,0,2.
4. Conflict: heating=cooling=1 while in OFF for 3 cycles → no enables asserted; req_conflict=1 on the 3 following cycles; state stays 0.
5. Lockout masking: cooling pulsed for 2 cycles entirely within LOCKOUT → no cooler_on. Cooling held from LOCKOUT into OFF → cooler_on rises 1 cycle after OFF is entered.
6. Async reset: rst_n driven low mid-COOL, between clock edges → all outputs 0 and state=0 without a clock edge. After release with cooling=1, cooler_on rises at the first edge.

Source files
------------

// File: rtl/hvac_actuator_ctrl.sv
// -----------------------------------------------------------------------------
// hvac_actuator_ctrl
//
// Takes the heat/cool requests from the air-conditioning controller and drives
// the physical heater, compressor and fan enables. The block protects the plant:
//   - once started, a heater or compressor run lasts at least MIN_ON cycles;
//   - every run is followed by MIN_OFF cycles of LOCKOUT, with all requests
//     ignored, before anything may start again;
//   - the fan keeps running for the first FAN_RUNON cycles of LOCKOUT;
//   - heater and compressor are mutually exclusive. A change of mode always
//     goes through LOCKOUT and then OFF.
// Simultaneous heat and cool requests are flagged on req_conflict, and in OFF
// they start nothing.
//
// Ports
//   clk          in   system clock, rising edge
//   rst_n        in   asynchronous active-low reset
//   heating      in   heat request
//   cooling      in   cool request
//   heater_on    out  heater enable (registered, high only in HEAT)
//   cooler_on    out  compressor enable (registered, high only in COOL)
//   fan_on       out  fan enable (registered)
//   req_conflict out  registered heating & cooling
//   state        out  FSM state: OFF=0, HEAT=1, COOL=2, LOCKOUT=3
// -----------------------------------------------------------------------------
module hvac_actuator_ctrl #(
  parameter int unsigned MIN_ON    = 4,
  parameter int unsigned MIN_OFF   = 3,
  parameter int unsigned FAN_RUNON = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       heating,
  input  logic       cooling,
  output logic       heater_on,
  output logic       cooler_on,
  output logic       fan_on,
  output logic       req_conflict,
  output logic [1:0] state
);

  // ---------------------------------------------------------------------------
  // Parameter sanity: reject configurations the timer cannot represent.
  // ---------------------------------------------------------------------------
  if (MIN_ON < 1)                 begin : g_bad_min_on   $error("MIN_ON must be >= 1");           end
  if (MIN_OFF < 1)                begin : g_bad_min_off  $error("MIN_OFF must be >= 1");          end
  if (FAN_RUNON > MIN_OFF)        begin : g_bad_runon    $error("FAN_RUNON must be <= MIN_OFF");  end
  if ((MIN_ON  >> CNT_W) != 0)    begin : g_wide_min_on  $error("MIN_ON does not fit in CNT_W");  end
  if ((MIN_OFF >> CNT_W) != 0)    begin : g_wide_min_off $error("MIN_OFF does not fit in CNT_W"); end

  // ---------------------------------------------------------------------------
  // State encoding (fixed: visible on the state port).
  // ---------------------------------------------------------------------------
  localparam logic [1:0] ST_OFF     = 2'd0;
  localparam logic [1:0] ST_HEAT    = 2'd1;
  localparam logic [1:0] ST_COOL    = 2'd2;
  localparam logic [1:0] ST_LOCKOUT = 2'd3;

  // Thresholds resized once to the timer width so every compare is same-width.
  localparam logic [CNT_W-1:0] MIN_ON_C    = CNT_W'(MIN_ON);
  localparam logic [CNT_W-1:0] MIN_OFF_C   = CNT_W'(MIN_OFF);
  localparam logic [CNT_W-1:0] FAN_RUNON_C = CNT_W'(FAN_RUNON);
  localparam logic [CNT_W-1:0] TIMER_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] TIMER_MAX   = {CNT_W{1'b1}};

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  logic [1:0]       state_q,    state_d;
  logic [CNT_W-1:0] timer_q,    timer_d;
  logic             heater_q,   heater_d;
  logic             cooler_q,   cooler_d;
  logic             fan_q,      fan_d;
  logic             conflict_q, conflict_d;

  // The timer counts cycles spent in the current state. It saturates instead
  // of wrapping, so a very long run still reads as having met MIN_ON.
  logic [CNT_W-1:0] timer_inc;
  assign timer_inc = (timer_q == TIMER_MAX) ? timer_q : timer_q + TIMER_ONE;

  // ---------------------------------------------------------------------------
  // Next-state and timer
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every always_comb output gets a default before the case, so no
    // path leaves it unassigned and no latch is inferred.
    state_d = state_q;
    timer_d = timer_inc;

    unique case (state_q)
      ST_OFF: begin
        timer_d = '0;
        // Both requests at once are a conflict: start neither.
        if (heating && !cooling) begin
          state_d = ST_HEAT;
          timer_d = TIMER_ONE;
        end else if (cooling && !heating) begin
          state_d = ST_COOL;
          timer_d = TIMER_ONE;
        end
      end

      // In a run only the matching request matters. The run ends once the
      // request has dropped and MIN_ON cycles have elapsed.
      ST_HEAT: begin
        if (!heating && (timer_q >= MIN_ON_C)) begin
          state_d = ST_LOCKOUT;
          timer_d = TIMER_ONE;
        end
      end

      ST_COOL: begin
        if (!cooling && (timer_q >= MIN_ON_C)) begin
          state_d = ST_LOCKOUT;
          timer_d = TIMER_ONE;
        end
      end

      // LOCKOUT ignores all requests. Anything still asserted is picked up in
      // OFF, which guarantees at least one idle cycle between runs.
      ST_LOCKOUT: begin
        if (timer_q >= MIN_OFF_C) begin
          state_d = ST_OFF;
          timer_d = '0;
        end
      end

      default: begin
        state_d = ST_OFF;
        timer_d = '0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // Outputs are decoded from the next state/timer and registered. An enable
  // therefore changes on the same edge as the state, with no extra cycle of
  // latency.
  always_comb begin
    heater_d   = (state_d == ST_HEAT);
    cooler_d   = (state_d == ST_COOL);
    // The timer reads 1 on the first LOCKOUT cycle, so "timer <= FAN_RUNON"
    // covers exactly the first FAN_RUNON cycles. FAN_RUNON = 0 gives no run-on.
    fan_d      = (state_d == ST_HEAT) || (state_d == ST_COOL) ||
                 ((state_d == ST_LOCKOUT) && (timer_d <= FAN_RUNON_C));
    conflict_d = heating & cooling;
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments. All registers then
  // update together from values sampled before the edge, whatever order the
  // blocks are evaluated in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_OFF;
      timer_q    <= '0;
      heater_q   <= 1'b0;
      cooler_q   <= 1'b0;
      fan_q      <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      timer_q    <= timer_d;
      heater_q   <= heater_d;
      cooler_q   <= cooler_d;
      fan_q      <= fan_d;
      conflict_q <= conflict_d;
    end
  end

  assign heater_on    = heater_q;
  assign cooler_on    = cooler_q;
  assign fan_on       = fan_q;
  assign req_conflict = conflict_q;
  assign state        = state_q;

endmodule

// File: tb/tb_hvac_actuator_ctrl.sv
// -----------------------------------------------------------------------------
// Self-checking bench for hvac_actuator_ctrl (MIN_ON=4, MIN_OFF=3, FAN_RUNON=2).
//
// The reference model tracks which phase the plant is in and stores the
// absolute edge number at which the current run or rest began. Durations are
// differences of edge numbers. A compare process checks every output against
// the model on each falling edge. Directed scenarios also carry hand-computed
// literal expectations that pin down the model itself.
// -----------------------------------------------------------------------------
module tb_hvac_actuator_ctrl;

  localparam int MIN_ON    = 4;
  localparam int MIN_OFF   = 3;
  localparam int FAN_RUNON = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       heating = 1'b0;
  logic       cooling = 1'b0;
  logic       heater_on, cooler_on, fan_on, req_conflict;
  logic [1:0] state;

  int n_tests = 0;
  int n_fail  = 0;

  hvac_actuator_ctrl #(
    .MIN_ON   (MIN_ON),
    .MIN_OFF  (MIN_OFF),
    .FAN_RUNON(FAN_RUNON),
    .CNT_W    (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .heating     (heating),
    .cooling     (cooling),
    .heater_on   (heater_on),
    .cooler_on   (cooler_on),
    .fan_on      (fan_on),
    .req_conflict(req_conflict),
    .state       (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: the phase plus the edge number at which it started.
  // ---------------------------------------------------------------------------
  typedef enum {P_IDLE, P_HEAT, P_COOL, P_REST} phase_t;

  phase_t m_phase    = P_IDLE;
  int     m_edge     = 0;   // rising edges seen since the start of simulation
  int     m_run_t0   = 0;   // edge number at which the current run started
  int     m_rest_t0  = 0;   // edge number at which the current rest started
  logic   m_conflict = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase    <= P_IDLE;
      m_conflict <= 1'b0;
    end else begin
      m_edge     <= m_edge + 1;
      m_conflict <= heating & cooling;
      case (m_phase)
        P_IDLE:
          if (heating != cooling) begin
            m_phase  <= heating ? P_HEAT : P_COOL;
            m_run_t0 <= m_edge;
          end
        P_HEAT, P_COOL:
          if (!(m_phase == P_HEAT ? heating : cooling) && (m_edge - m_run_t0 >= MIN_ON)) begin
            m_phase   <= P_REST;
            m_rest_t0 <= m_edge;
          end
        P_REST:
          if (m_edge - m_rest_t0 >= MIN_OFF) m_phase <= P_IDLE;
        default: m_phase <= P_IDLE;
      endcase
    end
  end

  function automatic int phase_code(input phase_t p);
    case (p)
      P_HEAT:  return 1;
      P_COOL:  return 2;
      P_REST:  return 3;
      default: return 0;
    endcase
  endfunction

  // Index of the current rest cycle: 0 on the first rest cycle.
  function automatic logic exp_fan();
    if (m_phase == P_HEAT || m_phase == P_COOL) return 1'b1;
    if (m_phase == P_REST) return (m_edge - m_rest_t0 - 1) < FAN_RUNON;
    return 1'b0;
  endfunction

  logic cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_heater",   heater_on,    m_phase == P_HEAT);
      check("model_cooler",   cooler_on,    m_phase == P_COOL);
      check("model_fan",      fan_on,       exp_fan());
      check("model_conflict", req_conflict, m_conflict);
      check("model_state",    state,        phase_code(m_phase));
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. Inputs change on the falling edge. After tick() returns,
  // the outputs reflect the rising edge that sampled (h, c).
  // ---------------------------------------------------------------------------
  task automatic tick(input logic h, input logic c);
    heating = h;
    cooling = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (state != 2'd0 && n < 40) begin
      tick(1'b0, 1'b0);
      n++;
    end
    check(name, state, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  int hc, lc, ovl;
  int s3[6];
  int exp3[6] = '{1, 3, 3, 3, 0, 2};

  initial begin
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_state",    state,        0);
    check("reset_heater",   heater_on,    0);
    check("reset_cooler",   cooler_on,    0);
    check("reset_fan",      fan_on,       0);
    check("reset_conflict", req_conflict, 0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    tick(1'b0, 1'b0);

    // 1. single-cycle heat pulse
    tick(1'b1, 1'b0);
    check("t1_heater_N", heater_on, 1);
    check("t1_fan_N",    fan_on,    1);
    check("t1_state_N",  state,     1);
    repeat (3) tick(1'b0, 1'b0);
    check("t1_heater_N3", heater_on, 1);
    tick(1'b0, 1'b0);
    check("t1_state_N4",  state,     3);
    check("t1_heater_N4", heater_on, 0);
    check("t1_fan_N4",    fan_on,    1);
    tick(1'b0, 1'b0);
    check("t1_fan_N5",    fan_on,    1);
    tick(1'b0, 1'b0);
    check("t1_fan_N6",    fan_on,    0);
    check("t1_state_N6",  state,     3);
    tick(1'b0, 1'b0);
    check("t1_state_N7",  state,     0);

    // 2. long request: ten edges high
    hc = 0; lc = 0;
    repeat (10) begin tick(1'b1, 1'b0); hc += int'(heater_on); end
    repeat (4)  begin tick(1'b0, 1'b0); hc += int'(heater_on); lc += int'(state == 2'd3); end
    check("t2_heater_cycles",  hc,    10);
    check("t2_lockout_cycles", lc,    3);
    check("t2_state_end",      state, 0);

    // 3. changeover from heat to cool after a 6-cycle heat run
    repeat (6) tick(1'b1, 1'b0);
    s3[0] = int'(state);
    ovl = 0;
    for (int i = 1; i < 6; i++) begin
      tick(1'b0, 1'b1);
      s3[i] = int'(state);
      ovl += int'(heater_on & cooler_on);
      if (i == 1) check("t3_heater_fall_E", heater_on, 0);
      if (i == 4) check("t3_cooler_low_E3", cooler_on, 0);
    end
    for (int i = 0; i < 6; i++) check($sformatf("t3_state_seq%0d", i), s3[i], exp3[i]);
    check("t3_cooler_rise_E4", cooler_on, 1);
    check("t3_no_overlap",     ovl,       0);
    wait_idle("t3_back_to_off");

    // 4. conflicting requests in OFF
    repeat (3) begin
      tick(1'b1, 1'b1);
      check("t4_conflict", req_conflict, 1);
      check("t4_heater",   heater_on,    0);
      check("t4_cooler",   cooler_on,    0);
      check("t4_state",    state,        0);
    end
    tick(1'b0, 1'b0);
    check("t4_conflict_clear", req_conflict, 0);

    // 5a. cool pulse entirely inside LOCKOUT is dropped
    tick(1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b0);
    check("t5_lockout", state, 3);
    repeat (2) begin
      tick(1'b0, 1'b1);
      check("t5_masked_cooler", cooler_on, 0);
    end
    tick(1'b0, 1'b0);
    check("t5_off_reached", state,     0);
    tick(1'b0, 1'b0);
    check("t5_still_off",   state,     0);
    check("t5_no_cooler",   cooler_on, 0);

    // 5b. cool held from LOCKOUT into OFF starts one cycle after OFF
    tick(1'b0, 1'b1);
    repeat (4) tick(1'b0, 1'b0);
    check("t5b_lockout", state, 3);
    repeat (2) tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    check("t5b_off_entry",   state,     0);
    check("t5b_cooler_off",  cooler_on, 0);
    tick(1'b0, 1'b1);
    check("t5b_cooler_rise", cooler_on, 1);
    check("t5b_state_cool",  state,     2);

    // 6. asynchronous reset mid-COOL, between clock edges
    tick(1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_state",    state,        0);
    check("t6_async_heater",   heater_on,    0);
    check("t6_async_cooler",   cooler_on,    0);
    check("t6_async_fan",      fan_on,       0);
    check("t6_async_conflict", req_conflict, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1'b0, 1'b1);
    check("t6_cooler_first_edge", cooler_on, 1);
    check("t6_state_cool",        state,     2);
    wait_idle("t6_back_to_off");

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
